binary_cellular_automata_runner: RTL and testbench
==================================================

# binary_cellular_automata_runner

Parametrised 2D binary (life-like) cellular automaton with a built-in run controller. It loads a seed grid, then applies a programmable survive/rise rule for a requested number of generations. It stops early on a still life when configured to, and signals completion with a one-cycle `done`. It is the next generation of the team's binary automaton core: it adds a selectable boundary mode, a generation counter and a start/busy/done handshake, so genetic-evaluation logic can drive it without counting clocks externally.

## Interface
Parameters:
- `Width`, 8, grid columns (≥3).
- `Height`, 8, grid rows (≥3).
- `CountWidth`, 16, width of the generation target and counter.
- `Wrap`, 1, 1 = toroidal edges; 0 = cells outside the grid read as dead.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: run request, sampled only in IDLE.
- `generations` input CountWidth: number of generations to run, sampled with `start`.
- `survive` input 9: bit n = live cell with n live neighbours stays alive.
- `rise` input 9: bit n = dead cell with n live neighbours becomes alive.
- `set` input Width*Height: seed grid, sampled with `start`.
- `state` output Width*Height: current grid; cell (x,y) is bit y*Width+x.
- `busy` output 1: high in RUN.
- `done` output 1: high for exactly one cycle (DONE state).
- `still` output 1: the last run ended on a still life.
- `gen_count` output CountWidth: generations applied in the current or last run.

## Operation
- Neighbourhood: 8-cell Moore neighbourhood; count 0..8 (4 bits) indexes `survive` or `rise`.
- With `Wrap`=1, x and y indices wrap modulo Width/Height. With `Wrap`=0, out-of-range neighbours count as 0.
- `survive`/`rise` are live inputs, read every RUN cycle and not latched.
- FSM states IDLE, RUN, DONE:
  - IDLE + `start`: `state`←`set`, `gen_count`←0, target←`generations`, `still`←0. Next state is RUN, or DONE if `generations`==0.
  - RUN: each cycle `state`←next grid and `gen_count`←`gen_count`+1. When the incremented count equals the target, go to DONE.
  - DONE: one cycle, then IDLE. `state`, `gen_count` and `still` hold until the next `start`.
- `start` while RUN or DONE is ignored. A `start` is not queued.
- Reset: `state`=0, `gen_count`=0, `busy`=0, `done`=0, `still`=0, FSM=IDLE. Reset overrides any in-progress run on the same edge.
- `gen_count` does not wrap: the target is ≤ 2^CountWidth−1, so the counter cannot exceed it.

## Timing
- `start` at edge k: `state`==`set` after edge k.
- For target N>0, generation i is visible after edge k+i. `done` is high during the cycle after edge k+N, and `busy` drops in that same cycle.
- For N=0, `done` is high during the cycle after edge k. `state`==`set` and `gen_count`=0.
- `busy` and `done` decode directly from the FSM register, with no extra latency.
- The earliest next `start` is accepted in the cycle after `done`.

## Configuration
- `CA_STILL_DETECT_EN` defined: in RUN, if next grid == `state`:
  - `still`←1 and go to DONE;
  - `gen_count` is not incremented;
  - `state` is unchanged.
- Without the macro, still-life comparison logic is absent and `still` is tied to 0. Runs always take exactly N generations.

## Structure
- Package `ca_pkg`:
  - FSM state enum typedef;
  - `CA_RULE_W`=9;
  - `CA_NCOUNT_W`=4.
- Sub-module `ca_cell_rule`: inputs are 8 neighbour bits, self bit, `survive` and `rise`; output is the next cell bit. It is purely combinational and generated Width*Height times.
- Top-level: neighbour gathering (Wrap-dependent generate), FSM, counter, still compare.

## Test plan
- Blinker, 8x8, Conway (`survive`=9'b000001100, `rise`=9'b000001000):
  - seed (3,2),(3,3),(3,4), `generations`=1 → `state`={(2,3),(3,3),(4,3)}, `done` one cycle after edge k+1, `gen_count`=1;
  - `generations`=2 → `state`==seed.
- Glider, 8x8, `Wrap`=1, Conway, `generations`=32 → `state`==seed, `gen_count`=32, `busy` high for exactly 32 cycles.
- `Wrap`=0, single live cell at (0,0), Conway, `generations`=1 → `state`=0. With `Wrap`=1, a 2x2 block straddling the (7,7)/(0,0) corner survives unchanged.
- `CA_STILL_DETECT_EN`, 2x2 block at (2,2), `generations`=100 → `done` after edge k+1, `still`=1, `gen_count`=0. Without the macro → 100 generations, `still`=0.
- `generations`=0 → `done` in the cycle after edge k, `state`==`set`. `start` pulsed during RUN → ignored, and `gen_count` is unaffected.
- `rst` asserted mid-run at generation 5 → next cycle `state`=0, `busy`=0, `done`=0, `gen_count`=0, FSM=IDLE. A following `start` runs normally.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types and widths for the binary cellular automaton runner.
package ca_pkg;

    localparam int unsigned CA_RULE_W   = 9;
    localparam int unsigned CA_NCOUNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ca_state_e;

endpackage

// File: rtl/ca_cell_rule.sv
// One cell of the automaton: counts live Moore neighbours and applies survive/rise.
module ca_cell_rule
    import ca_pkg::*;
(
    input  logic [7:0]           nbr_i,
    input  logic                 self_i,
    input  logic [CA_RULE_W-1:0] survive_i,
    input  logic [CA_RULE_W-1:0] rise_i,
    output logic                 next_o
);

    logic [CA_NCOUNT_W-1:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + CA_NCOUNT_W'(nbr_i[i]);
        end
        next_o = self_i ? survive_i[count] : rise_i[count];
    end

endmodule

// File: rtl/binary_cellular_automata_runner.sv
// Life-like 2D automaton with load/run/done controller.
// Optional still-life early stop when CA_STILL_DETECT_EN is defined.
module binary_cellular_automata_runner
    import ca_pkg::*;
#(
    parameter int Width      = 8,
    parameter int Height     = 8,
    parameter int CountWidth = 16,
    parameter int Wrap       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CountWidth-1:0]     generations,
    input  logic [CA_RULE_W-1:0]      survive,
    input  logic [CA_RULE_W-1:0]      rise,
    input  logic [Width*Height-1:0]   set,
    output logic [Width*Height-1:0]   state,
    output logic                      busy,
    output logic                      done,
    output logic                      still,
    output logic [CountWidth-1:0]     gen_count
);

    localparam int Cells = Width * Height;

    ca_state_e              fsm_q, fsm_d;
    logic [Cells-1:0]       grid_q, grid_d;
    logic [Cells-1:0]       next_grid;
    logic [CountWidth-1:0]  cnt_q, cnt_d;
    logic [CountWidth-1:0]  tgt_q, tgt_d;
    logic [CountWidth-1:0]  cnt_inc;

    // Neighbour gathering and per-cell rule evaluation
    for (genvar gy = 0; gy < Height; gy++) begin : g_row
        for (genvar gx = 0; gx < Width; gx++) begin : g_col
            logic [7:0] nbr;
            for (genvar k = 0; k < 8; k++) begin : g_nbr
                localparam int DI = (k < 4) ? k : k + 1;
                localparam int NX = gx + (DI % 3) - 1;
                localparam int NY = gy + (DI / 3) - 1;
                if (Wrap != 0) begin : g_wrap
                    localparam int WX = (NX + Width) % Width;
                    localparam int WY = (NY + Height) % Height;
                    assign nbr[k] = grid_q[WY*Width+WX];
                end else if (NX < 0 || NX >= Width || NY < 0 || NY >= Height) begin : g_edge
                    assign nbr[k] = 1'b0;
                end else begin : g_in
                    assign nbr[k] = grid_q[NY*Width+NX];
                end
            end
            ca_cell_rule u_rule (
                .nbr_i     (nbr),
                .self_i    (grid_q[gy*Width+gx]),
                .survive_i (survive),
                .rise_i    (rise),
                .next_o    (next_grid[gy*Width+gx])
            );
        end
    end

    assign cnt_inc = cnt_q + CountWidth'(1);

`ifdef CA_STILL_DETECT_EN
    logic still_q, still_d;
`endif

    always_comb begin
        fsm_d  = fsm_q;
        grid_d = grid_q;
        cnt_d  = cnt_q;
        tgt_d  = tgt_q;
`ifdef CA_STILL_DETECT_EN
        still_d = still_q;
`endif
        unique case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    grid_d = set;
                    cnt_d  = '0;
                    tgt_d  = generations;
`ifdef CA_STILL_DETECT_EN
                    still_d = 1'b0;
`endif
                    fsm_d  = (generations == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef CA_STILL_DETECT_EN
                // A grid that maps onto itself will never change again
                if (next_grid == grid_q) begin
                    still_d = 1'b1;
                    fsm_d   = ST_DONE;
                end else begin
                    grid_d = next_grid;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == tgt_q) fsm_d = ST_DONE;
                end
`else
                grid_d = next_grid;
                cnt_d  = cnt_inc;
                if (cnt_inc == tgt_q) fsm_d = ST_DONE;
`endif
            end
            ST_DONE: fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            grid_q <= '0;
            cnt_q  <= '0;
            tgt_q  <= '0;
`ifdef CA_STILL_DETECT_EN
            still_q <= 1'b0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            grid_q <= grid_d;
            cnt_q  <= cnt_d;
            tgt_q  <= tgt_d;
`ifdef CA_STILL_DETECT_EN
            still_q <= still_d;
`endif
        end
    end

    assign state     = grid_q;
    assign gen_count = cnt_q;
    assign busy      = (fsm_q == ST_RUN);
    assign done      = (fsm_q == ST_DONE);
`ifdef CA_STILL_DETECT_EN
    assign still     = still_q;
`else
    assign still     = 1'b0;
`endif

endmodule

// File: tb/tb_binary_cellular_automata_runner.sv
// Randomised and directed checks of the automaton runner, wrapped and bounded grids.
module tb_binary_cellular_automata_runner;

    localparam int W = 8;
    localparam int H = 8;
    localparam logic [8:0] CONWAY_S = 9'b000001100;
    localparam logic [8:0] CONWAY_R = 9'b000001000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_w = 1'b0;
    logic        start_n = 1'b0;
    logic [15:0] gens_i = '0;
    logic [8:0]  survive_i = CONWAY_S;
    logic [8:0]  rise_i = CONWAY_R;
    logic [63:0] set_i = '0;

    logic [63:0] st_w, st_n;
    logic        busy_w, busy_n, done_w, done_n, still_w, still_n;
    logic [15:0] gc_w, gc_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    binary_cellular_automata_runner #(.Width(W), .Height(H), .CountWidth(16), .Wrap(1)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .generations(gens_i),
        .survive(survive_i), .rise(rise_i), .set(set_i),
        .state(st_w), .busy(busy_w), .done(done_w), .still(still_w), .gen_count(gc_w)
    );

    binary_cellular_automata_runner #(.Width(W), .Height(H), .CountWidth(16), .Wrap(0)) dut_n (
        .clk(clk), .rst(rst), .start(start_n), .generations(gens_i),
        .survive(survive_i), .rise(rise_i), .set(set_i),
        .state(st_n), .busy(busy_n), .done(done_n), .still(still_n), .gen_count(gc_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One generation from the life-like rule, straight from the neighbourhood definition
    function automatic logic [63:0] ref_step(input logic [63:0] g, input bit wrap,
                                             input logic [8:0] sv, input logic [8:0] rs);
        logic [63:0] r;
        r = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int n;
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int xx, yy;
                        if (dx == 0 && dy == 0) continue;
                        xx = x + dx;
                        yy = y + dy;
                        if (wrap) begin
                            xx = (xx + W) % W;
                            yy = (yy + H) % H;
                        end else if (xx < 0 || xx >= W || yy < 0 || yy >= H) begin
                            continue;
                        end
                        n += int'(g[yy*W+xx]);
                    end
                end
                r[y*W+x] = g[y*W+x] ? sv[n] : rs[n];
            end
        end
        return r;
    endfunction

    task automatic run(input bit wrap, input logic [63:0] seed, input int gens,
                       input logic [8:0] sv, input logic [8:0] rs, input int poke,
                       output logic [63:0] fin);
        logic [63:0] exp, nxt;
        int cnt, lat, idx, busy_cnt;
        bit st;
        exp = seed;
        cnt = 0;
        st  = 1'b0;
        for (int i = 0; i < gens; i++) begin
            nxt = ref_step(exp, wrap, sv, rs);
`ifdef CA_STILL_DETECT_EN
            if (nxt == exp) begin
                st = 1'b1;
                break;
            end
`endif
            exp = nxt;
            cnt++;
        end
        lat = st ? cnt + 1 : cnt;

        @(negedge clk);
        set_i = seed;
        gens_i = 16'(gens);
        survive_i = sv;
        rise_i = rs;
        start_w = wrap;
        start_n = !wrap;
        @(posedge clk);
        #1;
        start_w = 1'b0;
        start_n = 1'b0;
        check("load_state", wrap ? st_w : st_n, seed);
        check("load_count", 64'(wrap ? gc_w : gc_n), 64'd0);

        idx = 0;
        busy_cnt = 0;
        while (!(wrap ? done_w : done_n) && idx < gens + 4) begin
            if (wrap ? busy_w : busy_n) busy_cnt++;
            if (idx == poke) begin
                start_w = wrap;
                start_n = !wrap;
                set_i = {$urandom, $urandom};
                gens_i = 16'd3;
            end
            @(posedge clk);
            #1;
            start_w = 1'b0;
            start_n = 1'b0;
            idx++;
        end
        check("done_edge", 64'(idx), 64'(lat));
        check("busy_cycles", 64'(busy_cnt), 64'(lat));
        check("final_state", wrap ? st_w : st_n, exp);
        check("gen_count", 64'(wrap ? gc_w : gc_n), 64'(cnt));
        check("still", 64'(wrap ? still_w : still_n), 64'(st));
        check("busy_at_done", 64'(wrap ? busy_w : busy_n), 64'd0);
        fin = wrap ? st_w : st_n;
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(wrap ? done_w : done_n), 64'd0);
        check("hold_state", wrap ? st_w : st_n, exp);
        check("hold_count", 64'(wrap ? gc_w : gc_n), 64'(cnt));
    endtask

    initial begin
        logic [63:0] fin, blinker, glider, corner, block;
        blinker = '0; blinker[19] = 1'b1; blinker[27] = 1'b1; blinker[35] = 1'b1;
        glider  = '0; glider[1] = 1'b1; glider[10] = 1'b1;
        glider[16] = 1'b1; glider[17] = 1'b1; glider[18] = 1'b1;
        corner  = '0; corner[0] = 1'b1; corner[7] = 1'b1; corner[56] = 1'b1; corner[63] = 1'b1;
        block   = '0; block[18] = 1'b1; block[19] = 1'b1; block[26] = 1'b1; block[27] = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_state", st_w, 64'd0);
        check("rst_busy", 64'(busy_w), 64'd0);
        check("rst_done", 64'(done_w), 64'd0);
        check("rst_still", 64'(still_w), 64'd0);
        check("rst_count", 64'(gc_w), 64'd0);

        run(1'b1, blinker, 1, CONWAY_S, CONWAY_R, -1, fin);
        check("blinker_h", fin, 64'h0000_0000_1C00_0000);
        run(1'b1, blinker, 2, CONWAY_S, CONWAY_R, -1, fin);
        check("blinker_back", fin, blinker);
        run(1'b1, glider, 32, CONWAY_S, CONWAY_R, -1, fin);
        check("glider_loop", fin, glider);
        run(1'b0, 64'd1, 1, CONWAY_S, CONWAY_R, -1, fin);
        check("lone_dies", fin, 64'd0);
        run(1'b1, corner, 3, CONWAY_S, CONWAY_R, -1, fin);
        check("corner_block", fin, corner);
        run(1'b1, block, 100, CONWAY_S, CONWAY_R, -1, fin);
        check("block_held", fin, block);
        run(1'b0, blinker, 0, CONWAY_S, CONWAY_R, -1, fin);
        check("zero_gen", fin, blinker);
        run(1'b1, glider, 10, CONWAY_S, CONWAY_R, 3, fin);

        // Reset in the middle of a run, then a clean run afterwards
        @(negedge clk);
        set_i = glider;
        gens_i = 16'd20;
        survive_i = CONWAY_S;
        rise_i = CONWAY_R;
        start_w = 1'b1;
        @(posedge clk);
        #1;
        start_w = 1'b0;
        for (int i = 0; i < 10 && gc_w != 16'd5; i++) begin
            @(posedge clk);
            #1;
        end
        check("midrun_gen5", 64'(gc_w), 64'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_state", st_w, 64'd0);
        check("mrst_busy", 64'(busy_w), 64'd0);
        check("mrst_done", 64'(done_w), 64'd0);
        check("mrst_count", 64'(gc_w), 64'd0);
        @(posedge clk);
        #1;
        check("mrst_idle", 64'(busy_w), 64'd0);
        run(1'b1, blinker, 1, CONWAY_S, CONWAY_R, -1, fin);

        for (int t = 0; t < 12; t++) begin
            run(1'($urandom_range(0, 1)), {$urandom, $urandom}, int'($urandom_range(0, 20)),
                9'($urandom), 9'($urandom), -1, fin);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
